// File: rtl/ram_req_queue.sv
// ram_req_queue
//   Bridges the CPU-side single-cycle RAM strobes onto a req/gnt + rvalid
//   memory handshake. Writes are posted into a small FIFO; a read waits
//   until every earlier write has been granted, then issues, waits for
//   rvalid and holds the data until the CPU acknowledges it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ram_addr            CPU request address
//   ram_wr_data         CPU write data
//   ram_wr_en/rd_en     CPU strobes, honoured only while ram_busy=0
//   ram_busy            CPU must not issue new strobes
//   ram_rd_data         read data, held while ram_rd_ready=1
//   ram_rd_ready        read data valid
//   ram_rd_ack          CPU consumed read data
//   mem_req/we/addr/wdata  memory request (we=1 write, we=0 read)
//   mem_gnt             memory accepts the request this cycle
//   mem_rvalid/rdata    memory read data (single-cycle pulse)
//   fifo_level          write FIFO occupancy
module ram_req_queue #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          ram_addr,
  input  logic [DATA_W-1:0]          ram_wr_data,
  input  logic                       ram_wr_en,
  input  logic                       ram_rd_en,
  output logic                       ram_busy,
  output logic [DATA_W-1:0]          ram_rd_data,
  output logic                       ram_rd_ready,
  input  logic                       ram_rd_ack,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_DRAIN,
    RD_ISSUE,
    RD_WAIT,
    RD_HOLD
  } state_t;

  state_t              state_reg;
  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       count_next;
  logic [ADDR_W-1:0]   rd_addr_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic                rd_ready_reg;

  // Write FIFO storage. The head is read combinationally so the memory
  // request can be presented the cycle after a push and held steady while
  // the memory withholds mem_gnt.
  logic [ADDR_W-1:0]   fifo_addr_mem [DEPTH];
  logic [DATA_W-1:0]   fifo_data_mem [DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic wr_accept;
  logic rd_accept;
  logic pop;
  logic rd_gnt;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(DEPTH));

  // Only registered state feeds ram_busy, so the CPU never sees a
  // combinational path from its own strobes.
  assign ram_busy  = fifo_full | (state_reg != IDLE);
  assign wr_accept = ram_wr_en & ~ram_busy;
  assign rd_accept = ram_rd_en & ~ram_busy;

  // Pending writes always take priority; a read is only presented once the
  // FIFO is empty, which keeps reads ordered behind earlier writes.
  assign pop    = ~fifo_empty & mem_gnt;
  assign rd_gnt = (state_reg == RD_ISSUE) & fifo_empty & mem_gnt;

  assign count_next = count_reg + CW'(wr_accept) - CW'(pop);

  assign mem_req   = ~fifo_empty | (state_reg == RD_ISSUE);
  assign mem_we    = ~fifo_empty;
  assign mem_addr  = !fifo_empty ? fifo_addr_mem[rd_ptr_reg]
                   : (state_reg == RD_ISSUE) ? rd_addr_reg : '0;
  assign mem_wdata = !fifo_empty ? fifo_data_mem[rd_ptr_reg] : '0;

  assign ram_rd_data  = rd_data_reg;
  assign ram_rd_ready = rd_ready_reg;
  assign fifo_level   = count_reg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      fifo_addr_mem[wr_ptr_reg] <= ram_addr;
      fifo_data_mem[wr_ptr_reg] <= ram_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)       rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rd_addr_reg  <= '0;
      rd_data_reg  <= '0;
      rd_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rd_accept) begin
            rd_addr_reg <= ram_addr;
            // A write accepted in the same cycle lands in the FIFO first,
            // so count_next already accounts for it.
            state_reg   <= (count_next == '0) ? RD_ISSUE : RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (fifo_empty) state_reg <= RD_ISSUE;
        end
        RD_ISSUE: begin
          if (rd_gnt) state_reg <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            rd_data_reg  <= mem_rdata;
            rd_ready_reg <= 1'b1;
            state_reg    <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (ram_rd_ack) begin
            rd_ready_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_queue.sv
// Directed bench for ram_req_queue. A small memory model answers granted
// requests (rvalid one cycle after a read grant) and logs every memory
// transaction so ordering can be checked against hand-computed sequences.
module tb_ram_req_queue;

  logic        clk;
  logic        rst_n;
  logic [23:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;
  logic        ram_rd_en;
  logic        ram_busy;
  logic [15:0] ram_rd_data;
  logic        ram_rd_ready;
  logic        ram_rd_ack;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_model [logic [23:0]];
  bit          log_we   [$];
  logic [23:0] log_addr [$];
  logic [15:0] log_data [$];

  ram_req_queue #(.ADDR_W(24), .DATA_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_busy(ram_busy), .ram_rd_data(ram_rd_data),
    .ram_rd_ready(ram_rd_ready), .ram_rd_ack(ram_rd_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: the memory model acts on the request visible this cycle,
  // then inputs may be changed #1 after the edge.
  task automatic step();
    bit          rd_issue;
    logic [23:0] a;
    rd_issue = 1'b0;
    a = '0;
    if (mem_req && mem_gnt && rst_n) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      $display("txn %s addr=0x%06h data=0x%04h", mem_we ? "WR" : "RD", mem_addr, mem_wdata);
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      else begin
        rd_issue = 1'b1;
        a = mem_addr;
      end
    end
    @(posedge clk);
    #1;
    mem_rvalid = rd_issue;
    mem_rdata  = (rd_issue && mem_model.exists(a)) ? mem_model[a] : 16'h0000;
  endtask

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (fifo_level == 3'd0) break;
      step();
    end
    check(tag, 32'(fifo_level), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (ram_rd_ready) break;
      step();
    end
    check(tag, 32'(ram_rd_ready), 32'd1);
  endtask

  task automatic check_log(input string tag, input int idx, input bit we,
                           input logic [23:0] a, input logic [15:0] d);
    if (idx < log_addr.size()) begin
      check({tag, "_we"}, 32'(log_we[idx]), 32'(we));
      check({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
      if (we) check({tag, "_data"}, 32'(log_data[idx]), 32'(d));
    end
  endtask

  bit       bad_order;
  bit [2:0] gnt_pat;

  initial begin
    rst_n = 1'b0; ram_addr = '0; ram_wr_data = '0; ram_wr_en = 0; ram_rd_en = 0;
    ram_rd_ack = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 32'(ram_busy), 0);
    check("rst_ready", 32'(ram_rd_ready), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_rdata", 32'(ram_rd_data), 0);
    check("rst_maddr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_level", 32'(fifo_level), 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(ram_busy), 0);
    check("idle_req", 32'(mem_req), 0);

    // Fill the FIFO with no grants, then drop a 5th strobe
    for (int i = 0; i < 4; i++) begin
      ram_wr_en = 1; ram_addr = 24'h10 + 24'(i); ram_wr_data = 16'hA000 + 16'(i);
      step();
    end
    ram_addr = 24'h14; ram_wr_data = 16'hA004;
    step();
    ram_wr_en = 0;
    check("full_level", 32'(fifo_level), 4);
    check("full_busy", 32'(ram_busy), 1);
    step();
    check("hold_req", 32'(mem_req), 1);
    check("hold_we", 32'(mem_we), 1);
    check("hold_addr", 32'(mem_addr), 32'h10);
    check("hold_wdata", 32'(mem_wdata), 32'hA000);
    mem_gnt = 1;
    wait_drain("fill_drain");
    check("fill_ntxn", log_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      check_log("fill", i, 1'b1, 24'h10 + 24'(i), 16'hA000 + 16'(i));

    // Minimum-latency read
    clear_log();
    mem_model[24'h20] = 16'h1234;
    ram_rd_en = 1; ram_addr = 24'h20;
    step();                              // cycle 0 accept
    ram_rd_en = 0;
    check("lat1_req", 32'(mem_req), 1);
    check("lat1_we", 32'(mem_we), 0);
    check("lat1_addr", 32'(mem_addr), 32'h20);
    step();                              // cycle 1 grant
    check("lat2_ready", 32'(ram_rd_ready), 0);
    check("lat2_rvalid_model", 32'(mem_rvalid), 1);
    step();                              // cycle 2 rvalid
    check("lat3_ready", 32'(ram_rd_ready), 1);
    check("lat3_data", 32'(ram_rd_data), 32'h1234);
    step();
    check("hold_ready", 32'(ram_rd_ready), 1);
    check("hold_data", 32'(ram_rd_data), 32'h1234);
    check("hold_busy", 32'(ram_busy), 1);
    ram_rd_ack = 1;
    step();
    ram_rd_ack = 0;
    check("ack_ready", 32'(ram_rd_ready), 0);
    check("ack_busy", 32'(ram_busy), 0);

    // Same-cycle write and read of one address
    clear_log();
    ram_wr_en = 1; ram_rd_en = 1; ram_addr = 24'h30; ram_wr_data = 16'hBEEF;
    step();
    ram_wr_en = 0; ram_rd_en = 0;
    wait_ready("wr_rd_ready");
    check("wr_rd_data", 32'(ram_rd_data), 32'hBEEF);
    check("wr_rd_ntxn", log_addr.size(), 2);
    check_log("wr_rd0", 0, 1'b1, 24'h30, 16'hBEEF);
    check_log("wr_rd1", 1, 1'b0, 24'h30, 16'h0);
    ram_rd_ack = 1; step(); ram_rd_ack = 0;

    // Queued writes then a read, with grants toggling 1,0,1
    clear_log();
    mem_gnt = 0;
    ram_wr_en = 1; ram_addr = 24'h40; ram_wr_data = 16'hC000; step();
    ram_addr = 24'h41; ram_wr_data = 16'hC001; step();
    ram_wr_en = 0; ram_rd_en = 1; ram_addr = 24'h41; step();
    ram_rd_en = 0;
    bad_order = 0;
    gnt_pat = 3'b101;
    for (int i = 0; i < 40; i++) begin
      if (ram_rd_ready) break;
      mem_gnt = gnt_pat[i % 3];
      if (mem_req && !mem_we && fifo_level != 3'd0) bad_order = 1;
      step();
    end
    check("tog_ready", 32'(ram_rd_ready), 1);
    check("tog_order", 32'(bad_order), 0);
    check("tog_ntxn", log_addr.size(), 3);
    check_log("tog0", 0, 1'b1, 24'h40, 16'hC000);
    check_log("tog1", 1, 1'b1, 24'h41, 16'hC001);
    check_log("tog2", 2, 1'b0, 24'h41, 16'h0);
    check("tog_data", 32'(ram_rd_data), 32'hC001);
    ram_rd_ack = 1; step(); ram_rd_ack = 0;
    mem_gnt = 1;

    // Stray rvalid in IDLE, then ack while nothing is ready
    mem_rvalid = 1; mem_rdata = 16'h5555;
    step();
    check("stray_ready", 32'(ram_rd_ready), 0);
    check("stray_busy", 32'(ram_busy), 0);
    check("stray_data", 32'(ram_rd_data), 32'hC001);
    ram_rd_ack = 1;
    step();
    ram_rd_ack = 0;
    check("ack0_ready", 32'(ram_rd_ready), 0);
    check("ack0_busy", 32'(ram_busy), 0);
    check("ack0_req", 32'(mem_req), 0);

    // Ten back-to-back writes across pointer wrap
    clear_log();
    ram_wr_en = 1;
    for (int i = 0; i < 10; i++) begin
      ram_addr = 24'h50 + 24'(i); ram_wr_data = 16'hD000 + 16'(i);
      step();
    end
    ram_wr_en = 0;
    wait_drain("wrap_drain");
    check("wrap_ntxn", log_addr.size(), 10);
    for (int i = 0; i < 10; i++)
      check_log("wrap", i, 1'b1, 24'h50 + 24'(i), 16'hD000 + 16'(i));

    // Reset while in RD_WAIT, then a late rvalid
    ram_rd_en = 1; ram_addr = 24'h20;
    step();
    ram_rd_en = 0;
    step();
    check("rw_busy", 32'(ram_busy), 1);
    rst_n = 0;
    #2;
    rst_n = 1;
    mem_rvalid = 1; mem_rdata = 16'h1234;
    step();
    check("rw_ready", 32'(ram_rd_ready), 0);
    check("rw_idle_busy", 32'(ram_busy), 0);
    check("rw_req", 32'(mem_req), 0);
    check("rw_rdata", 32'(ram_rd_data), 0);
    check("rw_level", 32'(fifo_level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
